// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
//   UART serializer. Frames each parallel word as one start bit, DATA_BITS
//   data bits (LSB first), an optional parity bit, and a stop period of
//   SB_TICKS oversampling ticks. Bit timing comes from an external
//   16x-oversampling tick (one s_tick pulse = 1/16 of a bit time).
//   A one-entry holding buffer decouples the host side from the shifter so
//   consecutive frames can be sent with no idle-high gap between them.
//
// Parameters
//   DATA_BITS   data bits per frame (5..9)
//   SB_TICKS    stop length in ticks: 16/24/32 = 1/1.5/2 stop bits (16..32)
//   PARITY_EN   1 = append a parity bit after the data bits
//   PARITY_ODD  1 = odd parity, 0 = even (ignored when PARITY_EN = 0)
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset
//   s_tick     in   oversampling tick, single-cycle pulse, 16 per bit
//   din        in   word to send
//   din_valid  in   din is valid; accepted on a clk edge while din_ready=1
//   din_ready  out  holding buffer empty
//   tx         out  serial line, driven from a flop, idles high
//   tx_busy    out  a frame is in progress (FSM not idle)
//   tx_done    out  single-cycle pulse as a frame's stop period completes
// ---------------------------------------------------------------------------
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int SB_TICKS   = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_tick,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int N_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [N_W-1:0] N_LAST      = N_W'(DATA_BITS - 1);
  localparam logic [4:0]     S_LAST_BIT  = 5'd15;
  localparam logic [4:0]     S_LAST_STOP = 5'(SB_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e               state_q;
  logic [4:0]           s_q;           // ticks elapsed within the current bit
  logic [N_W-1:0]       n_q;           // data bit index
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] hold_q;
  logic                 hold_valid_q;
  logic                 parity_q;
  logic                 tx_q;

  logic accept;
  logic bit_end;
  logic stop_end;
  logic parity_d;

  assign accept   = din_valid & ~hold_valid_q;
  assign bit_end  = s_tick & (s_q == S_LAST_BIT);
  assign stop_end = s_tick & (s_q == S_LAST_STOP);
  // Parity is taken from the holding buffer at load time so it stays fixed
  // for the frame while the shift register drains.
  assign parity_d = (^hold_q) ^ (PARITY_ODD != 0);

  assign din_ready = ~hold_valid_q;
  assign tx        = tx_q;
  assign tx_busy   = (state_q != IDLE);
  assign tx_done   = (state_q == STOP) & stop_end;

  // NOTE: every register here, including the data shift/hold registers, is
  // cleared by reset and updated only with non-blocking assignments, so all
  // reads in this block see pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      s_q          <= '0;
      n_q          <= '0;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      parity_q     <= 1'b0;
      tx_q         <= 1'b1;
    end else begin
      // Host write into the holding buffer. It can never coincide with a
      // reload below, since a reload needs hold_valid_q=1 and a write needs 0.
      if (accept) begin
        hold_q       <= din;
        hold_valid_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (hold_valid_q) begin
            shift_q      <= hold_q;
            parity_q     <= parity_d;
            hold_valid_q <= 1'b0;
            s_q          <= '0;
            state_q      <= START;
            tx_q         <= 1'b0;
          end
        end

        START: begin
          if (bit_end) begin
            s_q     <= '0;
            n_q     <= '0;
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end else if (s_tick) begin
            s_q <= s_q + 5'd1;
          end
        end

        DATA: begin
          if (bit_end) begin
            s_q     <= '0;
            shift_q <= shift_q >> 1;
            if (n_q == N_LAST) begin
              if (PARITY_EN != 0) begin
                state_q <= PARITY;
                tx_q    <= parity_q;
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              n_q  <= n_q + 1'b1;
              // Next bit on the line is the one about to reach shift_q[0].
              tx_q <= shift_q[1];
            end
          end else if (s_tick) begin
            s_q <= s_q + 5'd1;
          end
        end

        PARITY: begin
          if (bit_end) begin
            s_q     <= '0;
            state_q <= STOP;
            tx_q    <= 1'b1;
          end else if (s_tick) begin
            s_q <= s_q + 5'd1;
          end
        end

        STOP: begin
          if (stop_end) begin
            s_q <= '0;
            // Back-to-back: a word already waiting starts immediately, so the
            // start bit follows the stop period with no idle-high cycle.
            if (hold_valid_q) begin
              shift_q      <= hold_q;
              parity_q     <= parity_d;
              hold_valid_q <= 1'b0;
              state_q      <= START;
              tx_q         <= 1'b0;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          end else if (s_tick) begin
            s_q <= s_q + 5'd1;
          end
        end

        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
//   Directed bench for uart_tx. Four instances cover the configurations of
//   interest: default 8N1, 8E1, 8O1 and 7 data bits with a 32-tick stop.
//   A free-running generator supplies one s_tick every 4 clk. A monitor
//   counts, per instance, the ticks consumed while busy, so line samples are
//   taken mid-bit and the tx_done position is measured in ticks from the
//   start of the frame. Expected line patterns are hand-written constants,
//   indexed from the start bit (bit 0) upwards.
// ---------------------------------------------------------------------------
module tb_uart_tx;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic s_tick  = 1'b0;
  logic tick_en = 1'b0;

  logic [7:0] din0 = '0;
  logic [7:0] din1 = '0;
  logic [7:0] din2 = '0;
  logic [6:0] din3 = '0;
  logic [3:0] valid = '0;

  logic [3:0] ready_w;
  logic [3:0] tx_w;
  logic [3:0] busy_w;
  logic [3:0] done_w;

  int n_cmp = 0;
  int n_err = 0;

  int   ft[4]        = '{0, 0, 0, 0};
  int   start_ft[4]  = '{0, 0, 0, 0};
  int   done_cnt[4]  = '{0, 0, 0, 0};
  int   done_at[4]   = '{0, 0, 0, 0};
  int   idle_cnt[4]  = '{0, 0, 0, 0};
  logic [3:0] prev_busy = '0;

  always #5 clk = ~clk;

  uart_tx #(.DATA_BITS(8), .SB_TICKS(16), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .din(din0), .din_valid(valid[0]),
    .din_ready(ready_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0])
  );

  uart_tx #(.DATA_BITS(8), .SB_TICKS(16), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .din(din1), .din_valid(valid[1]),
    .din_ready(ready_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1])
  );

  uart_tx #(.DATA_BITS(8), .SB_TICKS(16), .PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .din(din2), .din_valid(valid[2]),
    .din_ready(ready_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2])
  );

  uart_tx #(.DATA_BITS(7), .SB_TICKS(32), .PARITY_EN(0), .PARITY_ODD(0)) u_dut3 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .din(din3), .din_valid(valid[3]),
    .din_ready(ready_w[3]), .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3])
  );

  // Tick generator: one-clk pulse every 4 clk while enabled, changed 1 time
  // unit after the rising edge so it is stable around both clock edges.
  initial begin
    int div;
    div = 0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_en) begin
        if (div == 3) begin
          s_tick = 1'b1;
          div    = 0;
        end else begin
          s_tick = 1'b0;
          div++;
        end
      end else begin
        s_tick = 1'b0;
      end
    end
  end

  // Per-instance frame monitor, sampled on the falling edge. A tick seen
  // here while busy is consumed by the DUT at the next rising edge.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (busy_w[i] && !prev_busy[i]) start_ft[i] = ft[i];
      if (busy_w[i] && s_tick) ft[i]++;
      if (done_w[i]) begin
        done_cnt[i]++;
        done_at[i] = ft[i] - start_ft[i];
      end
      if (!busy_w[i]) idle_cnt[i]++;
      prev_busy[i] = busy_w[i];
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Present one word to instance i; returns one clk after the frame starts.
  task automatic send(input int i, input logic [8:0] d);
    @(negedge clk);
    case (i)
      0: din0 = d[7:0];
      1: din1 = d[7:0];
      2: din2 = d[7:0];
      default: din3 = d[6:0];
    endcase
    valid[i] = 1'b1;
    @(negedge clk);
    valid[i] = 1'b0;
    check($sformatf("dut%0d_ready_after_write", i), ready_w[i], 1'b0);
    @(negedge clk);
    @(negedge clk);
    check($sformatf("dut%0d_start_tx", i), tx_w[i], 1'b0);
    check($sformatf("dut%0d_start_busy", i), busy_w[i], 1'b1);
  endtask

  task automatic wait_ft(input int i, input int target);
    int k;
    k = 0;
    while ((ft[i] - start_ft[i]) < target && k < 4000) begin
      @(negedge clk);
      k++;
    end
    if ((ft[i] - start_ft[i]) < target) begin
      n_cmp++;
      n_err++;
      $display("FAIL dut%0d_tick_wait: reached %0d ticks, required %0d",
               i, ft[i] - start_ft[i], target);
    end
  endtask

  // Sample the line in the middle of bit positions from..to of the frame.
  task automatic check_bits(input int i, input logic [31:0] frame, input int from,
                            input int to, input string name);
    for (int b = from; b <= to; b++) begin
      wait_ft(i, 8 + 16 * b);
      check($sformatf("%s_bit%0d", name, b), tx_w[i], frame[b]);
    end
  endtask

  task automatic wait_idle(input int i);
    int k;
    k = 0;
    while (busy_w[i] && k < 4000) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check($sformatf("dut%0d_returns_idle", i), busy_w[i], 1'b0);
  endtask

  initial begin
    int d0;
    int i0;
    int f0;

    // Reset state
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_tx%0d", i), tx_w[i], 1'b1);
      check($sformatf("rst_ready%0d", i), ready_w[i], 1'b1);
    end
    check("rst_busy0", busy_w[0], 1'b0);
    check("rst_done0", done_w[0], 1'b0);
    rst = 1'b0;
    tick_en = 1'b1;
    repeat (8) @(negedge clk);

    // Single default frame, 8'hA5: 0,1,0,1,0,0,1,0,1,1
    d0 = done_cnt[0];
    send(0, 9'h0A5);
    check("a5_ready_after_load", ready_w[0], 1'b1);
    check_bits(0, 32'b1101001010, 0, 9, "a5");
    wait_idle(0);
    check("a5_done_count", done_cnt[0] - d0, 1);
    check("a5_done_tick", done_at[0], 160);
    check("a5_idle_tx", tx_w[0], 1'b1);

    // Reset in the middle of the data bits
    d0 = done_cnt[0];
    send(0, 9'h0A5);
    wait_ft(0, 8 + 16 * 3);
    rst = 1'b1;
    #1;
    check("midrst_tx", tx_w[0], 1'b1);
    check("midrst_ready", ready_w[0], 1'b1);
    check("midrst_busy", busy_w[0], 1'b0);
    check("midrst_done", done_w[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (800) @(negedge clk);
    check("midrst_no_done", done_cnt[0] - d0, 0);
    check("midrst_still_idle", busy_w[0], 1'b0);
    check("midrst_line_high", tx_w[0], 1'b1);

    // Back-to-back: 8'h00 then 8'hFF queued while the first frame runs
    d0 = done_cnt[0];
    send(0, 9'h000);
    @(negedge clk);
    din0     = 8'hFF;
    valid[0] = 1'b1;
    @(negedge clk);
    valid[0] = 1'b0;
    check("b2b_ready_full", ready_w[0], 1'b0);
    i0 = idle_cnt[0];
    check_bits(0, 32'b1111111110_1000000000, 0, 9, "b2b");
    check("b2b_ready_during_stop", ready_w[0], 1'b0);
    check_bits(0, 32'b1111111110_1000000000, 10, 10, "b2b");
    check("b2b_ready_after_reload", ready_w[0], 1'b1);
    check("b2b_no_idle_gap", idle_cnt[0] - i0, 0);
    check_bits(0, 32'b1111111110_1000000000, 11, 19, "b2b");
    wait_idle(0);
    check("b2b_done_count", done_cnt[0] - d0, 2);
    check("b2b_second_done_tick", done_at[0], 320);

    // Even parity, 8'h07 -> parity bit 1, 176-tick frame
    send(1, 9'h007);
    check_bits(1, 32'b11000001110, 0, 10, "par_even");
    wait_idle(1);
    check("par_even_done_tick", done_at[1], 176);

    // Odd parity, 8'h07 -> parity bit 0
    send(2, 9'h007);
    check_bits(2, 32'b10000001110, 0, 10, "par_odd");
    wait_idle(2);
    check("par_odd_done_tick", done_at[2], 176);

    // 7 data bits, 32-tick stop, 7'h55
    send(3, 9'h055);
    check_bits(3, 32'b110101010, 0, 8, "sb32");
    wait_ft(3, 152);
    check("sb32_stop_late_tx", tx_w[3], 1'b1);
    check("sb32_stop_late_busy", busy_w[3], 1'b1);
    wait_idle(3);
    check("sb32_done_tick", done_at[3], 160);

    // Tick gating mid-data, 8'h3C
    d0 = done_cnt[0];
    send(0, 9'h03C);
    check_bits(0, 32'b1001111000, 0, 4, "gate");
    tick_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    f0 = ft[0];
    repeat (100) @(negedge clk);
    check("gate_no_ticks", ft[0] - f0, 0);
    check("gate_tx_frozen", tx_w[0], 1'b1);
    check("gate_busy", busy_w[0], 1'b1);
    tick_en = 1'b1;
    check_bits(0, 32'b1001111000, 5, 9, "gate");
    wait_idle(0);
    check("gate_done_count", done_cnt[0] - d0, 1);
    check("gate_done_tick", done_at[0], 160);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
